cell3_vector_driver: RTL
========================

Name: cell3_vector_driver

Overview:
- Sequential stimulus/response engine for any 3-input combinational cell (nand3, nor3, and3, aoi21, …).
- Drives the A1/A2/A3 cell inputs through all 8 vectors and samples the cell's ZN output after a programmable settle time.
- Compares each sample against a caller-supplied 8-bit truth table and reports pass/fail, a mismatch count and the first failing vector.
- Sits in the library self-test harness as the initiator side of the cell's input-to-output path.

Parameters:
- SETTLE_CYC, 2, clock cycles between driving a vector and sampling ZN; legal range 1..255.
- LOOPS, 1, number of full 8-vector sweeps per START; legal range 1..15.
- ERR_W, 8, width of ERR_CNT; the counter saturates at all-ones.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request to begin a run; sampled only in IDLE.
- TT  input  8  expected truth table; bit i = expected ZN for vector i; latched on an accepted START.
- ZN  input  1  output of the cell under test; assumed synchronous to CLK.
- A1  output  1  cell input, vector bit 0; registered.
- A2  output  1  cell input, vector bit 1; registered.
- A3  output  1  cell input, vector bit 2; registered.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse when a run completes.
- PASS  output  1  high when the last run had ERR_CNT==0; held until the next accepted START.
- ERR_CNT  output  ERR_W  mismatch count for the last or current run; saturating.
- FAIL_VLD  output  1  high once any mismatch has been seen in the current or last run.
- FAIL_VEC  output  3  index of the first failing vector; valid only when FAIL_VLD=1.

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, A1/A2/A3=000, latched TT=0, loop and settle counters 0. RST asserted mid-run aborts the run immediately; no DONE pulse.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - START=1 latches TT, clears ERR_CNT, FAIL_VLD, FAIL_VEC and PASS, sets vec=0 and loop=0, then goes to DRIVE.
  - BUSY rises on the cycle after START is sampled.
- DRIVE (1 cycle): {A3,A2,A1}<=vec, settle counter<=0, then go to SETTLE.
- SETTLE (SETTLE_CYC cycles): counts up and goes to SAMPLE when count==SETTLE_CYC-1. A-outputs are held stable.
- SAMPLE (1 cycle): compares ZN with TT[vec].
  - On mismatch, ERR_CNT increments unless already at all-ones.
  - On the first mismatch of the run, FAIL_VLD<=1 and FAIL_VEC<=vec.
  - If vec!=7: vec<=vec+1 and go to DRIVE.
  - If vec==7 and loop!=LOOPS-1: vec wraps to 0, loop+1, go to DRIVE.
  - Otherwise go to FINISH.
- FINISH (1 cycle): DONE=1, BUSY=0, PASS<=(ERR_CNT==0, counting the final sample's result), A-outputs<=000, then go to IDLE.
- Timing: BUSY is high for exactly LOOPS*8*(SETTLE_CYC+2) cycles. DONE is asserted in the first cycle with BUSY low.
- START while BUSY is ignored. START in the FINISH cycle is also ignored; a new run needs START in IDLE.
- TT changes after START have no effect on the current run.
- ERR_CNT saturation: it stays at 2^ERR_W-1 and PASS still evaluates to 0.

Optional Feature:
- Macro CELL3_VECTOR_DRIVER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes straight to FINISH. The rest of the sweep and loops are skipped, ERR_CNT=1, and DONE pulses one cycle after that SAMPLE.
- Undefined: every vector in every loop is always applied and sampled.

Decomposition:
- Package cell3_vector_driver_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, SAMPLE, FINISH);
  - VEC_W=3 and NUM_VEC=8;
  - truth-table constants TT_NAND3=8'h7F, TT_NOR3=8'h01, TT_AND3=8'h80.
- One natural sub-module: cell3_vector_driver_settle_cnt. It is the settle-cycle down/up counter with load and terminal-count output. All other logic stays in the top module.

Test Plan:
- Loopback to a behavioural nand3 (ZN=~(A1&A2&A3)), TT=8'h7F, SETTLE_CYC=2, LOOPS=1 -> A-vectors 0..7 in order, BUSY high for exactly 32 cycles, DONE pulse, PASS=1, ERR_CNT=0, FAIL_VLD=0.
- Same nand3 loopback with TT=8'h01 (nor3 expected) -> ERR_CNT=6, FAIL_VLD=1, FAIL_VEC=1, PASS=0.
- ZN stuck at 1, TT=8'h7F, LOOPS=3 -> ERR_CNT=3, FAIL_VEC=7, BUSY high for 96 cycles.
- START pulsed again at cycle 10 of a run, and TT changed mid-run -> run length unchanged, results match the originally latched TT; a START applied after DONE starts a fresh run with counters cleared.
- RST asserted at cycle 15 of a run -> next cycle all outputs 0, A=000, no DONE; a subsequent START runs normally.
- With CELL3_VECTOR_DRIVER_STOP_ON_FAIL_EN, ZN stuck at 0, TT=8'h7F -> fails at vector 0, ERR_CNT=1, FAIL_VEC=0, DONE on the cycle after the first SAMPLE (cycle 5 after START).

Source files
------------

// File: rtl/cell3_vector_driver_pkg.sv
// cell3_vector_driver_pkg
// Shared types and constants for the 3-input cell vector driver.
//   state_e  : run-sequencing FSM states
//   VEC_W    : width of a vector index ({A3,A2,A1})
//   NUM_VEC  : number of input vectors in one sweep
//   TT_*     : truth tables for common cells, bit i = ZN for vector i
package cell3_vector_driver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned NUM_VEC = 8;

  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_AND3  = 8'h80;

endpackage

// File: rtl/cell3_vector_driver_if.sv
// cell3_vector_driver_if
// Bundles the request, truth table, cell stimulus/response and result
// signals of the vector driver.
//   master : the driver (drives A1..A3 and results; receives START, TT, ZN)
//   slave  : the harness / cell side (drives START, TT, ZN)
// Parameter ERR_W must match the driver's ERR_W.
interface cell3_vector_driver_if #(
  parameter int unsigned ERR_W = 8
);

  logic             START;
  logic [7:0]       TT;
  logic             ZN;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic             FAIL_VLD;
  logic [2:0]       FAIL_VEC;

  modport master (
    input  START, TT, ZN,
    output A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC
  );

  modport slave (
    output START, TT, ZN,
    input  A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC
  );

endinterface

// File: rtl/cell3_vector_driver_settle_cnt.sv
// cell3_vector_driver_settle_cnt
// Settle-time counter. Cleared by load, counts up while en is high and
// flags the terminal count (SETTLE_CYC-1) so the caller knows this is the
// last settle cycle.
//   CLK, RST : clock, asynchronous active-high reset
//   load     : clear the count to 0
//   en       : advance the count by one
//   tc       : en is high and the count has reached SETTLE_CYC-1
module cell3_vector_driver_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(SETTLE_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/cell3_vector_driver.sv
// cell3_vector_driver
// Stimulus/response engine for a 3-input combinational cell. Each run
// applies all 8 input vectors LOOPS times, waits SETTLE_CYC cycles per
// vector, samples ZN and compares it with the truth table latched at START.
//   CLK, RST : clock, asynchronous active-high reset (aborts a run)
//   bus      : cell3_vector_driver_if master modport
//              START/TT in, ZN from the cell, A1..A3 to the cell,
//              BUSY/DONE/PASS/ERR_CNT/FAIL_VLD/FAIL_VEC results
// Build option: define CELL3_VECTOR_DRIVER_STOP_ON_FAIL_EN to end a run at
// the first mismatching sample instead of completing every sweep.
module cell3_vector_driver
  import cell3_vector_driver_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LOOPS      = 1,
  parameter int unsigned ERR_W      = 8
) (
  input logic                  CLK,
  input logic                  RST,
  cell3_vector_driver_if.master bus
);

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [3:0]       LOOP_LAST = 4'(LOOPS - 1);
  localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VEC - 1);

  state_e           state_q,    state_d;
  logic [7:0]       tt_q,       tt_d;
  logic [VEC_W-1:0] vec_q,      vec_d;
  logic [VEC_W-1:0] a_q,        a_d;
  logic [3:0]       loop_q,     loop_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
  logic             fail_vld_q, fail_vld_d;
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
  logic             pass_q,     pass_d;

  logic cnt_load;
  logic cnt_en;
  logic cnt_tc;
  logic mism;
  logic stop_now;

  cell3_vector_driver_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  assign mism = (bus.ZN != tt_q[vec_q]);

`ifdef CELL3_VECTOR_DRIVER_STOP_ON_FAIL_EN
  assign stop_now = mism;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tt_d       = tt_q;
    vec_d      = vec_q;
    a_d        = a_q;
    loop_d     = loop_q;
    err_cnt_d  = err_cnt_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          tt_d       = bus.TT;
          err_cnt_d  = '0;
          fail_vld_d = 1'b0;
          fail_vec_d = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          loop_d     = 4'd0;
          state_d    = DRIVE;
        end
      end

      DRIVE: begin
        a_d      = vec_q;
        cnt_load = 1'b1;
        state_d  = SETTLE;
      end

      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (mism) begin
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          // Only the first mismatch of the run is recorded.
          if (!fail_vld_q) begin
            fail_vld_d = 1'b1;
            fail_vec_d = vec_q;
          end
        end
        if (stop_now) begin
          state_d = FINISH;
        end else if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = DRIVE;
        end else if (loop_q != LOOP_LAST) begin
          vec_d   = '0;
          loop_d  = loop_q + 4'd1;
          state_d = DRIVE;
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // err_cnt_q already includes the last sample's result here.
        pass_d  = (err_cnt_q == '0);
        a_d     = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      tt_q       <= 8'd0;
      vec_q      <= '0;
      a_q        <= '0;
      loop_q     <= 4'd0;
      err_cnt_q  <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tt_q       <= tt_d;
      vec_q      <= vec_d;
      a_q        <= a_d;
      loop_q     <= loop_d;
      err_cnt_q  <= err_cnt_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
    end
  end

  // BUSY covers DRIVE/SETTLE/SAMPLE only, so DONE lands on the first
  // cycle with BUSY low.
  assign bus.BUSY     = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.DONE     = (state_q == FINISH);
  assign bus.A1       = a_q[0];
  assign bus.A2       = a_q[1];
  assign bus.A3       = a_q[2];
  assign bus.PASS     = pass_q;
  assign bus.ERR_CNT  = err_cnt_q;
  assign bus.FAIL_VLD = fail_vld_q;
  assign bus.FAIL_VEC = fail_vec_q;

endmodule
